// File: rtl/arb_pkg.sv
// Shared types and sizing for the 4-requester round-robin arbiter.
// Optional hold timeout is enabled in rr_arbiter4 by defining ARB_TIMEOUT_EN.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

endpackage : arb_pkg

// File: rtl/grant_dec2to4.sv
// Combinational 2-to-4 one-hot decoder; output is all-zero while en is low.
module grant_dec2to4
  import arb_pkg::*;
(
  input  logic                en,
  input  logic [ID_W-1:0]     id,
  output logic [NUM_REQ-1:0]  onehot
);

  // Expand the owner index into a one-hot grant pattern
  always_comb begin
    onehot = 4'b0000;
    if (en) begin
      case (id)
        2'd0:    onehot = 4'b0001;
        2'd1:    onehot = 4'b0010;
        2'd2:    onehot = 4'b0100;
        2'd3:    onehot = 4'b1000;
        default: onehot = 4'b0000;
      endcase
    end else begin
      onehot = 4'b0000;
    end
  end

endmodule : grant_dec2to4

// File: rtl/rr_arbiter4.sv
// 4-requester round-robin arbiter with release handshake and registered one-hot grant.
// Define ARB_TIMEOUT_EN to force release after TIMEOUT_CYC cycles of continuous ownership.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               busy,
  output logic               timeout
);

  arb_state_e         state_r;
  logic [NUM_REQ-1:0] gnt_r;
  logic [ID_W-1:0]    gnt_id_r;
  logic [ID_W-1:0]    ptr_r;
  logic               busy_r;
  logic               timeout_r;

  logic [NUM_REQ-1:0] req_rot_s;
  logic [ID_W-1:0]    rot_idx_s;
  logic [ID_W-1:0]    winner_s;
  logic               any_req_s;
  logic               release_s;
  logic               force_s;
  logic               dec_en_s;
  logic [ID_W-1:0]    dec_id_s;
  logic [NUM_REQ-1:0] dec_gnt_s;

  // An illegal sizing leaves this named scope in the elaborated hierarchy
  if ((TIMEOUT_CYC < 2) || (TIMEOUT_CYC > 255) || ((2 ** CNT_W) <= TIMEOUT_CYC)) begin : g_illegal_timeout_cfg
  end

  // Rotate requests so that bit 0 corresponds to the requester at ptr
  always_comb begin
    req_rot_s = 4'b0000;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_rot_s[i] = req[ID_W'(i) + ptr_r];
    end
  end

  // Fixed-priority encode of the rotated vector, lowest bit first
  always_comb begin
    rot_idx_s = 2'd0;
    casez (req_rot_s)
      4'b???1: rot_idx_s = 2'd0;
      4'b??10: rot_idx_s = 2'd1;
      4'b?100: rot_idx_s = 2'd2;
      4'b1000: rot_idx_s = 2'd3;
      default: rot_idx_s = 2'd0;
    endcase
  end

  assign winner_s  = rot_idx_s + ptr_r;
  assign any_req_s = |req;
  assign release_s = done | ~req[gnt_id_r] | ~en;

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt_r;

  // Hold counter: zero while idle so each grant starts counting from zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_IDLE) begin
      hold_cnt_r <= {CNT_W{1'b0}};
    end else begin
      hold_cnt_r <= hold_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // A real release condition on the last allowed cycle takes precedence over the timeout
  assign force_s = (hold_cnt_r == CNT_W'(TIMEOUT_CYC - 1)) & ~release_s;
`else
  assign force_s = 1'b0;
`endif

  // Select what the grant register loads on the next edge
  always_comb begin
    dec_en_s = 1'b0;
    dec_id_s = gnt_id_r;
    case (state_r)
      ST_IDLE: begin
        if (en && any_req_s) begin
          dec_en_s = 1'b1;
          dec_id_s = winner_s;
        end else begin
          dec_en_s = 1'b0;
          dec_id_s = gnt_id_r;
        end
      end
      ST_GRANT: begin
        if (release_s || force_s) begin
          dec_en_s = 1'b0;
        end else begin
          dec_en_s = 1'b1;
        end
        dec_id_s = gnt_id_r;
      end
      default: begin
        dec_en_s = 1'b0;
        dec_id_s = gnt_id_r;
      end
    endcase
  end

  grant_dec2to4 u_dec (
    .en     (dec_en_s),
    .id     (dec_id_s),
    .onehot (dec_gnt_s)
  );

  // Arbiter FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      gnt_r     <= 4'b0000;
      gnt_id_r  <= 2'd0;
      ptr_r     <= 2'd0;
      busy_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      gnt_r <= dec_gnt_s;
      case (state_r)
        ST_IDLE: begin
          timeout_r <= 1'b0;
          if (en && any_req_s) begin
            state_r  <= ST_GRANT;
            gnt_id_r <= winner_s;
            busy_r   <= 1'b1;
          end else begin
            busy_r   <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (release_s || force_s) begin
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            ptr_r     <= gnt_id_r + 2'd1;
            timeout_r <= force_s;
          end else begin
            busy_r    <= 1'b1;
            timeout_r <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          busy_r    <= 1'b0;
          timeout_r <= 1'b0;
        end
      endcase
    end
  end

  assign gnt     = gnt_r;
  assign gnt_id  = gnt_id_r;
  assign busy    = busy_r;
`ifdef ARB_TIMEOUT_EN
  assign timeout = timeout_r;
`else
  assign timeout = 1'b0;
`endif

endmodule : rr_arbiter4

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: directed vector table, hand-written corner sequences,
// then randomized traffic checked against an ownership-level reference model.
module tb_rr_arbiter4;

  localparam int TO_CYC = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the resource, last owner, next search start, hold age
  int m_owner;
  int m_last;
  int m_ptr;
  int m_hold;
  bit m_to;

  typedef struct packed {
    logic       en;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
  } vec_t;

  vec_t vec [22];

  always #5 clk = ~clk;

  rr_arbiter4 #(.TIMEOUT_CYC(TO_CYC), .CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  function automatic logic [7:0] outs();
    return {gnt, gnt_id, busy, timeout};
  endfunction

  function automatic logic [7:0] model_outs();
    logic [3:0] g;
    logic       b;
    g = 4'b0000;
    b = 1'b0;
    if (m_owner >= 0) begin
      g = 4'b0001 << m_owner;
      b = 1'b1;
    end
    return {g, 2'(m_last), b, m_to};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: gnt/id/busy/timeout got %b_%b_%b_%b required %b_%b_%b_%b",
               name, act[7:4], act[3:2], act[1], act[0], exp[7:4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 0;
    m_ptr   = 0;
    m_hold  = 0;
    m_to    = 1'b0;
  endtask

  task automatic model_step(input bit e, input logic [3:0] r, input bit d);
    bit rel;
    bit frc;
    bit found;
    int idx;
    if (m_owner < 0) begin
      m_to  = 1'b0;
      found = 1'b0;
      if (e && (r != 4'b0000)) begin
        for (int k = 0; k < 4; k++) begin
          idx = (m_ptr + k) % 4;
          if (!found && r[idx]) begin
            found   = 1'b1;
            m_owner = idx;
            m_last  = idx;
            m_hold  = 0;
          end
        end
      end
    end else begin
      rel = d || !r[m_owner] || !e;
      frc = TO_EN && !rel && (m_hold == TO_CYC - 1);
      if (rel || frc) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
        m_to    = frc;
      end else begin
        m_hold++;
        m_to = 1'b0;
      end
    end
  endtask

  // One clock: inputs are stable across the edge, outputs sampled 1 ns later
  task automatic tick();
    bit         e;
    logic [3:0] r;
    bit         d;
    e = en;
    r = req;
    d = done;
    @(posedge clk);
    model_step(e, r, d);
    #1;
  endtask

  initial begin
    vec[0]  = '{1'b1, 4'hF,    1'b1, 4'b0000, 2'd0, 1'b0};
    vec[1]  = '{1'b1, 4'hF,    1'b0, 4'b0010, 2'd1, 1'b1};
    vec[2]  = '{1'b1, 4'hF,    1'b1, 4'b0000, 2'd1, 1'b0};
    vec[3]  = '{1'b1, 4'hF,    1'b0, 4'b0100, 2'd2, 1'b1};
    vec[4]  = '{1'b1, 4'hF,    1'b1, 4'b0000, 2'd2, 1'b0};
    vec[5]  = '{1'b1, 4'hF,    1'b0, 4'b1000, 2'd3, 1'b1};
    vec[6]  = '{1'b1, 4'hF,    1'b1, 4'b0000, 2'd3, 1'b0};
    vec[7]  = '{1'b1, 4'hF,    1'b0, 4'b0001, 2'd0, 1'b1};
    vec[8]  = '{1'b1, 4'b0100, 1'b0, 4'b0000, 2'd0, 1'b0};
    vec[9]  = '{1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1};
    vec[10] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0};
    vec[11] = '{1'b1, 4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1};
    vec[12] = '{1'b1, 4'b0101, 1'b1, 4'b0000, 2'd0, 1'b0};
    vec[13] = '{1'b1, 4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1};
    vec[14] = '{1'b0, 4'b0101, 1'b0, 4'b0000, 2'd2, 1'b0};
    vec[15] = '{1'b0, 4'hF,    1'b0, 4'b0000, 2'd2, 1'b0};
    vec[16] = '{1'b0, 4'hF,    1'b1, 4'b0000, 2'd2, 1'b0};
    vec[17] = '{1'b1, 4'hF,    1'b1, 4'b1000, 2'd3, 1'b1};
    vec[18] = '{1'b1, 4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1};
    vec[19] = '{1'b1, 4'b1110, 1'b0, 4'b1000, 2'd3, 1'b1};
    vec[20] = '{1'b1, 4'b1110, 1'b1, 4'b0000, 2'd3, 1'b0};
    vec[21] = '{1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1};

    // Reset held with all requests pending
    rst  = 1'b1;
    en   = 1'b1;
    req  = 4'hF;
    done = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", outs(), 8'b0000_00_0_0);
    rst = 1'b0;
    tick();
    check("first_grant", outs(), 8'b0001_00_1_0);

    // Round robin, wrap/skip, withdraw, enable and ignored-event vectors
    for (int i = 0; i < 22; i++) begin
      en   = vec[i].en;
      req  = vec[i].req;
      done = vec[i].done;
      tick();
      check($sformatf("vec%0d", i), outs(), {vec[i].gnt, vec[i].id, vec[i].busy, 1'b0});
    end

    // Asynchronous reset between edges while requester 2 owns the resource
    rst = 1'b1;
    #1;
    check("async_rst_mid_grant", outs(), 8'b0000_00_0_0);
    model_reset();
    @(posedge clk);
    #1;
    rst  = 1'b0;
    req  = 4'b1001;
    done = 1'b0;
    en   = 1'b1;
    tick();
    check("ptr_cleared_by_rst", outs(), 8'b0001_00_1_0);

    // Single long-held request: forced release only when the timeout is built in
    req = 4'b0010;
    tick();
    check("withdraw_owner0", outs(), 8'b0000_00_0_0);
    for (int c = 0; c < TO_CYC; c++) begin
      tick();
      check($sformatf("hold_cycle%0d", c), outs(), 8'b0010_01_1_0);
    end
    tick();
    check("timeout_edge", outs(), TO_EN ? 8'b0000_01_0_1 : 8'b0010_01_1_0);
    tick();
    check("after_timeout", outs(), 8'b0010_01_1_0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      en = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 3) == 0) begin
        req = 4'($urandom_range(0, 15));
      end
      done = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        #1;
        check("rand_async_rst", outs(), 8'b0000_00_0_0);
        model_reset();
        #1;
        rst = 1'b0;
      end
      tick();
      check($sformatf("rand%0d", n), outs(), model_outs());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_rr_arbiter4
